// File: rtl/mmio_slot_arbiter.sv
// Round-robin arbiter sharing one MMIO slot bus between NUM_REQ requesters,
// with a per-transaction watchdog and a population mask for absent slots.
module mmio_slot_arbiter #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [15:0] SLOT_MASK      = 16'h0001
) (
   input  logic                    aclk,
   input  logic                    arst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [4*NUM_REQ-1:0]    req_slot,
   input  logic [8*NUM_REQ-1:0]    req_reg_addr,
   input  logic [32*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      req_accept,
   output logic [NUM_REQ-1:0]      resp_valid,
   input  logic [NUM_REQ-1:0]      resp_ready,
   output logic [31:0]             resp_rdata,
   output logic [1:0]              resp_code,
   output logic [15:0]             slot_chip_select,
   output logic                    read,
   output logic                    write,
   output logic [7:0]              reg_addr,
   output logic [31:0]             slot_wr_data,
   input  logic [15:0][31:0]       slot_rd_data,
   input  logic [15:0]             slot_wr_done,
   input  logic [15:0]             slot_rd_done,
   input  logic [15:0]             slot_slave_error,
   input  logic [15:0]             slot_decode_error,
   output logic                    busy,
   output logic [7:0]              timeout_count
);

   localparam int unsigned PTR_W = (NUM_REQ > 2) ? 2 : 1;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   state_e             state_q,  state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   grant_q,  grant_d;
   logic               wr_q,     wr_d;
   logic [3:0]         slot_q,   slot_d;
   logic [7:0]         addr_q,   addr_d;
   logic [31:0]        wdata_q,  wdata_d;
   logic [WD_W-1:0]    wdog_q,   wdog_d;
   logic [31:0]        rdata_q,  rdata_d;
   logic [1:0]         code_q,   code_d;
   logic [7:0]         tcount_q, tcount_d;

   logic [3:0]         slot_arr  [NUM_REQ];
   logic [7:0]         addr_arr  [NUM_REQ];
   logic [31:0]        wdata_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign slot_arr[i]  = req_slot[4*i +: 4];
      assign addr_arr[i]  = req_reg_addr[8*i +: 8];
      assign wdata_arr[i] = req_wdata[32*i +: 32];
   end

   // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ.
   logic               found;
   logic [PTR_W-1:0]   win;
   logic [PTR_W-1:0]   cand;
   int                 scan_idx;

   always_comb begin
      found    = 1'b0;
      win      = '0;
      cand     = '0;
      scan_idx = 0;
      for (int off = 0; off < int'(NUM_REQ); off++) begin
         scan_idx = int'(rr_ptr_q) + off;
         if (scan_idx >= int'(NUM_REQ)) scan_idx = scan_idx - int'(NUM_REQ);
         cand = PTR_W'(scan_idx);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   logic slot_done;
   assign slot_done = wr_q ? slot_wr_done[slot_q] : slot_rd_done[slot_q];

   // NOTE: every output and next-state signal gets a default at the top of this
   // block so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      grant_d          = grant_q;
      wr_d             = wr_q;
      slot_d           = slot_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      wdog_d           = wdog_q;
      rdata_d          = rdata_q;
      code_d           = code_q;
      tcount_d         = tcount_q;
      req_accept       = '0;
      resp_valid       = '0;
      resp_rdata       = '0;
      resp_code        = '0;
      slot_chip_select = '0;
      read             = 1'b0;
      write            = 1'b0;
      reg_addr         = '0;
      slot_wr_data     = '0;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               // Accept is gated by reset so outputs read zero while arst is held.
               if (!arst) req_accept[win] = 1'b1;
               grant_d  = win;
               wr_d     = req_write[win];
               slot_d   = slot_arr[win];
               addr_d   = addr_arr[win];
               wdata_d  = wdata_arr[win];
               rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
               wdog_d   = '0;
               if (!SLOT_MASK[slot_arr[win]]) begin
                  rdata_d = '0;
                  code_d  = RESP_DECERR;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            slot_chip_select = 16'(1) << slot_q;
            write            = wr_q;
            read             = !wr_q;
            reg_addr         = addr_q;
            slot_wr_data     = wdata_q;
            if (slot_done) begin
               rdata_d = wr_q ? 32'h0 : slot_rd_data[slot_q];
               if (slot_slave_error[slot_q])       code_d = RESP_SLVERR;
               else if (slot_decode_error[slot_q]) code_d = RESP_DECERR;
               else                                code_d = RESP_OKAY;
               state_d = ST_RESP;
            end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = '0;
               code_d  = RESP_SLVERR;
               if (tcount_q != 8'hFF) tcount_d = tcount_q + 8'd1;
               state_d = ST_RESP;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         ST_RESP: begin
            resp_valid[grant_q] = 1'b1;
            resp_rdata          = rdata_q;
            resp_code           = code_q;
            if (resp_ready[grant_q]) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign busy          = (state_q != ST_IDLE);
   assign timeout_count = tcount_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of block ordering.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         wr_q     <= 1'b0;
         slot_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wdog_q   <= '0;
         rdata_q  <= '0;
         code_q   <= '0;
         tcount_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         wr_q     <= wr_d;
         slot_q   <= slot_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wdog_q   <= wdog_d;
         rdata_q  <= rdata_d;
         code_q   <= code_d;
         tcount_q <= tcount_d;
      end
   end

endmodule
